// File: rtl/storage_controller.sv
// storage_controller: word storage from on-chip SRAM or SPI flash, with programmer passthrough
module storage_controller #(
  parameter int          SRAM_WORDS  = 2048,
  parameter logic [7:0]  READ_OPCODE = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_access,
  input  logic        memory_is_writing,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic [3:0]  mem_be,
  input  logic        set_programming_mode,
  input  logic        external_storage_spi_miso,
  input  logic        programming_spi_cs_n,
  input  logic        programming_spi_sck,
  input  logic        programming_spi_mosi,
  output logic [31:0] d_out,
  output logic        out_valid,
  output logic        external_storage_spi_cs_n,
  output logic        external_storage_spi_sck,
  output logic        external_storage_spi_mosi,
  output logic        programming_spi_miso
);
  localparam int AW = $clog2(SRAM_WORDS);
  typedef enum logic [2:0] {IDLE, RD_DECODE, SRAM_RD, SPI_XFER, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] d_out_q, d_out_d, shift_q, shift_d, rx_q, rx_d, ram_q;
  logic        cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mem [SRAM_WORDS];
  logic        in_sram, sram_we, sram_re;
  assign in_sram = addr < 32'(SRAM_WORDS);
  assign sram_we = !set_programming_mode && state_q == IDLE && memory_access && memory_is_writing && in_sram;
  assign sram_re = !set_programming_mode && state_q == RD_DECODE && in_sram;
  // SRAM array: byte-enabled write, registered read consumed in SRAM_RD
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (sram_we && mem_be[k]) mem[addr[AW-1:0]][8*k +: 8] <= d_in[8*k +: 8];
    if (sram_re) ram_q <= mem[addr[AW-1:0]];
  end
  // Next-state logic; one SPI bit is a low cycle then a high cycle, miso captured at the end of the high cycle
  always_comb begin
    state_d = state_q;
    d_out_d = d_out_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:      if (memory_access) state_d = memory_is_writing ? DONE : RD_DECODE;
      RD_DECODE: if (in_sram) state_d = SRAM_RD;
                 else begin
                   state_d = SPI_XFER;
                   cs_n_d  = 1'b0;
                   sck_d   = 1'b0;
                   cnt_d   = '0;
                   shift_d = {READ_OPCODE, addr[23:0]};
                   mosi_d  = READ_OPCODE[7];
                 end
      SRAM_RD:   begin
                   d_out_d = ram_q;
                   state_d = DONE;
                 end
      SPI_XFER:  if (!sck_q) sck_d = 1'b1;
                 else begin
                   sck_d   = 1'b0;
                   cnt_d   = cnt_q + 6'd1;
                   shift_d = {shift_q[30:0], 1'b0};
                   mosi_d  = shift_q[30];
                   if (cnt_q[5]) rx_d = {rx_q[30:0], external_storage_spi_miso};
                   if (&cnt_q) begin
                     state_d = DONE;
                     cs_n_d  = 1'b1;
                     mosi_d  = 1'b0;
                     d_out_d = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
                   end
                 end
      DONE:      if (!memory_access) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (set_programming_mode) begin
      state_d = IDLE;
      cs_n_d  = 1'b1;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
    end
  end
  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_out_q <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cnt_q   <= cnt_d;
    end
  end
  assign d_out                     = d_out_q;
  assign out_valid                 = state_q == DONE && !set_programming_mode;
  assign external_storage_spi_cs_n = set_programming_mode ? programming_spi_cs_n : cs_n_q;
  assign external_storage_spi_sck  = set_programming_mode ? programming_spi_sck  : sck_q;
  assign external_storage_spi_mosi = set_programming_mode ? programming_spi_mosi : mosi_q;
  assign programming_spi_miso      = set_programming_mode & external_storage_spi_miso;
endmodule

// File: tb/tb_storage_controller.sv
// tb_storage_controller: directed checks of SRAM, SPI flash read, passthrough and reset
module tb_storage_controller;
  logic        clk = 0, rst = 0;
  logic        memory_access = 0, memory_is_writing = 0;
  logic [31:0] addr = 0, d_in = 0;
  logic [3:0]  mem_be = 0;
  logic        set_programming_mode = 0;
  logic        prog_cs_n = 1, prog_sck = 0, prog_mosi = 0;
  logic        tb_miso = 0, flash_miso = 0, use_flash = 0;
  logic        miso_w;
  logic [31:0] d_out;
  logic        out_valid, ext_cs_n, ext_sck, ext_mosi, prog_miso;
  int          n_checks = 0, n_err = 0;
  int          fl_bits = 0, cs_falls = 0;
  logic [31:0] fl_cmd = 0;
  logic [31:0] fl_data = 32'hAABBCCDD;
  assign miso_w = use_flash ? flash_miso : tb_miso;
  storage_controller dut (
    .clk(clk), .rst(rst),
    .memory_access(memory_access), .memory_is_writing(memory_is_writing),
    .addr(addr), .d_in(d_in), .mem_be(mem_be),
    .set_programming_mode(set_programming_mode),
    .external_storage_spi_miso(miso_w),
    .programming_spi_cs_n(prog_cs_n), .programming_spi_sck(prog_sck), .programming_spi_mosi(prog_mosi),
    .d_out(d_out), .out_valid(out_valid),
    .external_storage_spi_cs_n(ext_cs_n), .external_storage_spi_sck(ext_sck),
    .external_storage_spi_mosi(ext_mosi), .programming_spi_miso(prog_miso)
  );
  always #5 clk = ~clk;
  // Flash model: collect command bits on sck rise, present read data on sck fall
  always @(negedge ext_cs_n) begin
    fl_bits = 0;
    fl_cmd = 0;
    cs_falls++;
  end
  always @(posedge ext_sck) if (!ext_cs_n) begin
    if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], ext_mosi};
    fl_bits++;
  end
  always @(negedge ext_sck) if (!ext_cs_n && fl_bits >= 32 && fl_bits < 64) flash_miso = fl_data[63-fl_bits];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    memory_access = 1; memory_is_writing = 1; addr = a; d_in = d; mem_be = be;
    step();
    memory_access = 0; memory_is_writing = 0;
    step();
  endtask
  task automatic do_read(input logic [31:0] a0, input logic [31:0] a1, output logic [31:0] d, output int lat);
    memory_access = 1; memory_is_writing = 0; addr = a0;
    step();
    addr = a1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    d = d_out;
    memory_access = 0;
    step();
  endtask
  initial begin
    logic [31:0] d;
    int lat;
    #2 rst = 1;
    #1;
    chk("rst_dout", d_out, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_cs_n", {31'b0, ext_cs_n}, 1);
    chk("rst_sck", {31'b0, ext_sck}, 0);
    chk("rst_mosi", {31'b0, ext_mosi}, 0);
    chk("rst_pmiso", {31'b0, prog_miso}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    step();
    set_programming_mode = 1;
    for (int v = 0; v < 8; v++) begin
      {prog_mosi, prog_sck, prog_cs_n} = 3'(v);
      #1;
      chk("pass_pins", {29'b0, ext_mosi, ext_sck, ext_cs_n}, 32'(v));
    end
    tb_miso = 0; #1 chk("pass_miso0", {31'b0, prog_miso}, 0);
    tb_miso = 1; #1 chk("pass_miso1", {31'b0, prog_miso}, 1);
    memory_access = 1; memory_is_writing = 1;
    step();
    chk("pass_no_valid", {31'b0, out_valid}, 0);
    memory_access = 0; memory_is_writing = 0;
    set_programming_mode = 0; prog_cs_n = 1; prog_sck = 0; prog_mosi = 0;
    #1 chk("nopass_miso", {31'b0, prog_miso}, 0);
    step();
    for (int i = 0; i < 2048; i++) begin
      do_write(i, i, 4'hF);
      do_read(i, i, d, lat);
      chk("sram_data", d, i);
      chk("sram_lat", lat, 3);
    end
    do_write(5, 32'hFFFFFFFF, 4'hF);
    memory_access = 1; memory_is_writing = 1; addr = 5; d_in = 32'h12345678; mem_be = 4'b0101;
    step();
    chk("wr_valid", {31'b0, out_valid}, 1);
    chk("wr_keeps_dout", d_out, 32'h7FF);
    memory_access = 0; memory_is_writing = 0;
    step();
    do_read(5, 5, d, lat);
    chk("be_data", d, 32'hFF34FF78);
    use_flash = 1;
    cs_falls = 0;
    do_read(0, 32'h00001001, d, lat);
    chk("ext_data", d, 32'hDDCCBBAA);
    chk("ext_lat", lat, 130);
    chk("ext_cmd", fl_cmd, 32'h03001001);
    chk("ext_bits", fl_bits, 64);
    chk("ext_cs_falls", cs_falls, 1);
    chk("ext_cs_end", {31'b0, ext_cs_n}, 1);
    chk("ext_sck_end", {31'b0, ext_sck}, 0);
    chk("ext_mosi_end", {31'b0, ext_mosi}, 0);
    memory_access = 1; addr = 32'h2000;
    repeat (21) step();
    chk("mode_cs_before", {31'b0, ext_cs_n}, 0);
    {prog_mosi, prog_sck, prog_cs_n} = 3'b110;
    set_programming_mode = 1;
    #1;
    chk("mode_pins", {29'b0, ext_mosi, ext_sck, ext_cs_n}, 32'b110);
    chk("mode_valid", {31'b0, out_valid}, 0);
    memory_access = 0;
    step();
    set_programming_mode = 0; prog_cs_n = 1; prog_sck = 0; prog_mosi = 0;
    #1;
    chk("mode_idle_cs", {31'b0, ext_cs_n}, 1);
    chk("mode_idle_sck", {31'b0, ext_sck}, 0);
    step();
    chk("mode_idle_valid", {31'b0, out_valid}, 0);
    memory_access = 1; addr = 32'h3000;
    repeat (40) step();
    chk("rst_mid_cs_before", {31'b0, ext_cs_n}, 0);
    #2 rst = 1;
    #1;
    chk("rst_mid_cs", {31'b0, ext_cs_n}, 1);
    chk("rst_mid_sck", {31'b0, ext_sck}, 0);
    chk("rst_mid_valid", {31'b0, out_valid}, 0);
    chk("rst_mid_dout", d_out, 0);
    memory_access = 0;
    step();
    rst = 0;
    step();
    do_read(5, 5, d, lat);
    chk("post_rst_data", d, 32'hFF34FF78);
    chk("post_rst_lat", lat, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
